// File: rtl/riscv_pkg.sv
// riscv_pkg -- definitions shared across the RISC-V pipeline stages.
//   * XLEN / RADDR_W : default datapath and register-index widths
//   * F3_*           : load funct3 encodings (size in [1:0], unsigned in [2])
//   * memwb_t        : payload carried by the MEM/WB pipeline register
package riscv_pkg;

  localparam int XLEN    = 64;
  localparam int RADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Raw load data and offset are carried into WB so that extraction happens
  // after the pipeline register, off the memory-return timing path.
  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic               memtoreg;
    logic [RADDR_W-1:0] rd;
    logic [2:0]         funct3;
    logic [2:0]         addr_lo;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    rdata;
  } memwb_t;

endpackage

// File: rtl/load_extract.sv
// load_extract -- purely combinational load byte/half/word/double extraction.
// The doubleword is shifted right by the byte offset (zero-filled from the
// top, so bytes past offset 7 read as zero), then sign- or zero-extended
// according to funct3. funct3 = 3'b111 is not a load: legal_o drops low.
// Ports:
//   rdata_i   in  XLEN  raw doubleword from data memory
//   addr_lo_i in  3     byte offset within the doubleword
//   funct3_i  in  3     load size/sign encoding
//   data_o    out XLEN  extracted, extended value
//   legal_o   out 1     funct3 names a real load
module load_extract #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o,
  output logic            legal_o
);
  import riscv_pkg::*;

  logic [XLEN-1:0] sh;

  assign sh = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o  = sh;
    legal_o = 1'b1;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){sh[7]}},   sh[7:0]};
      F3_LH:   data_o = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_LW:   data_o = {{(XLEN-32){sh[31]}}, sh[31:0]};
      F3_LD:   data_o = sh;
      F3_LBU:  data_o = {{(XLEN-8){1'b0}},    sh[7:0]};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}},   sh[15:0]};
      F3_LWU:  data_o = {{(XLEN-32){1'b0}},   sh[31:0]};
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage -- MEM/WB pipeline register plus the writeback datapath.
// Selects ALU result or extracted load data, drives the register-file write
// port and provides a same-cycle write-through bypass to the two ID reads.
// Optional feature: define WB_RETIRE_CNT_EN to add a 64-bit retired
// instruction counter on retire_cnt_o.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall_i, flush_i          hold / bubble the MEM/WB register (flush wins)
//   mem_*_i                   MEM-stage instruction fields
//   wb_valid_o, wb_we_o,
//   wb_rd_o, wb_wd_o          WB-stage valid and register-file write port
//   id_rs{1,2}_i,
//   id_rs{1,2}_data_i         ID read addresses and register-file read data
//   id_rs{1,2}_data_o         read data with WB write bypassed in
//   retire_cnt_o              retired-instruction count (WB_RETIRE_CNT_EN)
module wb_stage #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               mem_valid_i,
  input  logic               mem_regwrite_i,
  input  logic               mem_memtoreg_i,
  input  logic [RADDR_W-1:0] mem_rd_i,
  input  logic [2:0]         mem_funct3_i,
  input  logic [2:0]         mem_addr_lo_i,
  input  logic [XLEN-1:0]    mem_alu_result_i,
  input  logic [XLEN-1:0]    mem_rdata_i,
  output logic               wb_valid_o,
  output logic               wb_we_o,
  output logic [RADDR_W-1:0] wb_rd_o,
  output logic [XLEN-1:0]    wb_wd_o,
  input  logic [RADDR_W-1:0] id_rs1_i,
  input  logic [RADDR_W-1:0] id_rs2_i,
  input  logic [XLEN-1:0]    id_rs1_data_i,
  input  logic [XLEN-1:0]    id_rs2_data_i,
  output logic [XLEN-1:0]    id_rs1_data_o,
  output logic [XLEN-1:0]    id_rs2_data_o
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]        retire_cnt_o
`endif
);
  import riscv_pkg::*;

  memwb_t          memwb_q, memwb_d;
  logic [XLEN-1:0] ld_data;
  logic            ld_legal;

  // Next-state for the MEM/WB register; reset is applied in the flop.
  // A flush clears the whole payload, which also keeps regwrite low.
  always_comb begin
    memwb_d = memwb_q;
    if (flush_i) begin
      memwb_d = '0;
    end else if (!stall_i) begin
      memwb_d.valid      = mem_valid_i;
      memwb_d.regwrite   = mem_regwrite_i;
      memwb_d.memtoreg   = mem_memtoreg_i;
      memwb_d.rd         = mem_rd_i;
      memwb_d.funct3     = mem_funct3_i;
      memwb_d.addr_lo    = mem_addr_lo_i;
      memwb_d.alu_result = mem_alu_result_i;
      memwb_d.rdata      = mem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memwb_q <= '0;
    end else begin
      memwb_q <= memwb_d;
    end
  end

  load_extract #(
    .XLEN (XLEN)
  ) u_load_extract (
    .rdata_i   (memwb_q.rdata),
    .addr_lo_i (memwb_q.addr_lo),
    .funct3_i  (memwb_q.funct3),
    .data_o    (ld_data),
    .legal_o   (ld_legal)
  );

  // Only loads can be illegal; an ALU op with funct3=111 still writes.
  assign wb_valid_o = memwb_q.valid;
  assign wb_we_o    = memwb_q.valid & memwb_q.regwrite & (memwb_q.rd != '0)
                    & (ld_legal | ~memwb_q.memtoreg);
  assign wb_rd_o    = memwb_q.rd;
  assign wb_wd_o    = memwb_q.memtoreg ? ld_data : memwb_q.alu_result;

  // Write-through bypass; x0 is excluded because wb_we_o is never set for it.
  assign id_rs1_data_o = (wb_we_o && (wb_rd_o == id_rs1_i)) ? wb_wd_o : id_rs1_data_i;
  assign id_rs2_data_o = (wb_we_o && (wb_rd_o == id_rs2_i)) ? wb_wd_o : id_rs2_data_i;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;

  // An instruction retires on the edge that moves it out of WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else if (memwb_q.valid && !stall_i) begin
      retire_cnt_q <= retire_cnt_q + 64'd1;
    end
  end

  assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage -- scoreboard testbench for wb_stage. Expected WB contents are
// pushed when stimulus is driven and popped/compared after the clock edge.
// Define WB_RETIRE_CNT_EN to also exercise the retire counter.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic        mem_valid_i;
  logic        mem_regwrite_i;
  logic        mem_memtoreg_i;
  logic [4:0]  mem_rd_i;
  logic [2:0]  mem_funct3_i;
  logic [2:0]  mem_addr_lo_i;
  logic [63:0] mem_alu_result_i;
  logic [63:0] mem_rdata_i;
  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_wd_o;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic [63:0] id_rs1_data_i;
  logic [63:0] id_rs2_data_i;
  logic [63:0] id_rs1_data_o;
  logic [63:0] id_rs2_data_o;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_o;
  logic [63:0] cnt_exp;
`endif

  wb_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .mem_valid_i      (mem_valid_i),
    .mem_regwrite_i   (mem_regwrite_i),
    .mem_memtoreg_i   (mem_memtoreg_i),
    .mem_rd_i         (mem_rd_i),
    .mem_funct3_i     (mem_funct3_i),
    .mem_addr_lo_i    (mem_addr_lo_i),
    .mem_alu_result_i (mem_alu_result_i),
    .mem_rdata_i      (mem_rdata_i),
    .wb_valid_o       (wb_valid_o),
    .wb_we_o          (wb_we_o),
    .wb_rd_o          (wb_rd_o),
    .wb_wd_o          (wb_wd_o),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_rs1_data_i    (id_rs1_data_i),
    .id_rs2_data_i    (id_rs2_data_i),
    .id_rs1_data_o    (id_rs1_data_o),
    .id_rs2_data_o    (id_rs2_data_o)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt_o     (retire_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] wd;
    bit          chk_rd;
    bit          chk_wd;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  localparam logic [63:0] RD_PAT = 64'h8899AABB_CCDDEEFF;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference load extraction built byte-by-byte; returns {legal, data}.
  function automatic logic [64:0] ref_load(input logic [63:0] rdata,
                                           input logic [2:0] off,
                                           input logic [2:0] f3);
    logic [7:0]  b [8];
    logic [63:0] d;
    int          n;
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx  = i + int'(off);
      b[i] = (idx < 8) ? rdata[idx*8 +: 8] : 8'h00;
    end
    n = 1 << f3[1:0];
    d = '0;
    for (int i = 0; i < n; i++) d[i*8 +: 8] = b[i];
    if (!f3[2] && n < 8 && b[n-1][7])
      for (int i = n; i < 8; i++) d[i*8 +: 8] = 8'hFF;
    return {f3 != 3'b111, d};
  endfunction

  task automatic set_mem(input logic v, input logic rw, input logic m2r,
                         input logic [4:0] rd, input logic [2:0] f3,
                         input logic [2:0] off, input logic [63:0] alu,
                         input logic [63:0] rdata);
    mem_valid_i      = v;
    mem_regwrite_i   = rw;
    mem_memtoreg_i   = m2r;
    mem_rd_i         = rd;
    mem_funct3_i     = f3;
    mem_addr_lo_i    = off;
    mem_alu_result_i = alu;
    mem_rdata_i      = rdata;
  endtask

  // One clock: predict, push, advance, pop and compare.
  task automatic cycle();
    exp_t        e;
    logic [64:0] ld;
    if (rst) begin
      e = '{valid: 1'b0, we: 1'b0, rd: 5'd0, wd: 64'd0, chk_rd: 1'b1, chk_wd: 1'b1};
    end else if (flush_i) begin
      e = '{valid: 1'b0, we: 1'b0, rd: 5'd0, wd: 64'd0, chk_rd: 1'b0, chk_wd: 1'b0};
    end else if (stall_i) begin
      e = last_exp;
    end else begin
      ld = ref_load(mem_rdata_i, mem_addr_lo_i, mem_funct3_i);
      e.valid  = mem_valid_i;
      e.we     = mem_valid_i & mem_regwrite_i & (mem_rd_i != 5'd0) & (ld[64] | ~mem_memtoreg_i);
      e.rd     = mem_rd_i;
      e.wd     = mem_memtoreg_i ? ld[63:0] : mem_alu_result_i;
      e.chk_rd = 1'b1;
      e.chk_wd = ld[64] | ~mem_memtoreg_i;
    end
`ifdef WB_RETIRE_CNT_EN
    if (rst) cnt_exp = '0;
    else if (last_exp.valid && !stall_i) cnt_exp = cnt_exp + 64'd1;
`endif
    sb.push_back(e);
    last_exp = e;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    txn++;
    check("valid", {63'd0, wb_valid_o}, {63'd0, e.valid});
    check("we",    {63'd0, wb_we_o},    {63'd0, e.we});
    if (e.chk_rd) check("rd", {59'd0, wb_rd_o}, {59'd0, e.rd});
    if (e.chk_wd) check("wd", wb_wd_o, e.wd);
`ifdef WB_RETIRE_CNT_EN
    check("retire_cnt", retire_cnt_o, cnt_exp);
`endif
    $display("txn %0d: rst=%0b stall=%0b flush=%0b -> valid=%0b we=%0b rd=%0d wd=%h",
             txn, rst, stall_i, flush_i, wb_valid_o, wb_we_o, wb_rd_o, wb_wd_o);
  endtask

  task automatic check_bypass(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [63:0] d1, input logic [63:0] d2);
    logic [63:0] e1, e2;
    id_rs1_i = rs1; id_rs2_i = rs2; id_rs1_data_i = d1; id_rs2_data_i = d2;
    #1;
    e1 = (last_exp.we && last_exp.rd == rs1) ? last_exp.wd : d1;
    e2 = (last_exp.we && last_exp.rd == rs2) ? last_exp.wd : d2;
    check("byp_rs1", id_rs1_data_o, e1);
    check("byp_rs2", id_rs2_data_o, e2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    last_exp = '{valid: 1'b0, we: 1'b0, rd: 5'd0, wd: 64'd0, chk_rd: 1'b1, chk_wd: 1'b1};
`ifdef WB_RETIRE_CNT_EN
    cnt_exp = '0;
`endif
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    id_rs1_i = '0; id_rs2_i = '0; id_rs1_data_i = '0; id_rs2_data_i = '0;
    set_mem(1'b1, 1'b1, 1'b0, 5'd3, 3'd0, 3'd0, 64'hAAAA, 64'd0);
    @(posedge clk); #1;

    // Reset with a valid instruction presented: two reset cycles.
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_drop_valid", {63'd0, wb_valid_o}, 64'd0);
    check("rst_drop_wd", wb_wd_o, 64'd0);
    cycle();
    check("first_instr_rd", {59'd0, wb_rd_o}, 64'd3);

    // ALU write.
    set_mem(1'b1, 1'b1, 1'b0, 5'd5, 3'd0, 3'd0, 64'h1234, 64'd0);
    cycle();
    check("alu_wd", wb_wd_o, 64'h1234);

    // Loads from the fixed pattern.
    set_mem(1'b1, 1'b1, 1'b1, 5'd10, 3'b000, 3'd0, 64'd0, RD_PAT); cycle();
    check("lb_off0", wb_wd_o, 64'hFFFF_FFFF_FFFF_FFFF);
    set_mem(1'b1, 1'b1, 1'b1, 5'd11, 3'b100, 3'd1, 64'd0, RD_PAT); cycle();
    check("lbu_off1", wb_wd_o, 64'h0000_0000_0000_00EE);
    set_mem(1'b1, 1'b1, 1'b1, 5'd12, 3'b001, 3'd6, 64'd0, RD_PAT); cycle();
    check("lh_off6", wb_wd_o, 64'hFFFF_FFFF_FFFF_8899);
    set_mem(1'b1, 1'b1, 1'b1, 5'd13, 3'b110, 3'd4, 64'd0, RD_PAT); cycle();
    check("lwu_off4", wb_wd_o, 64'h0000_0000_8899_AABB);
    set_mem(1'b1, 1'b1, 1'b1, 5'd14, 3'b011, 3'd0, 64'd0, RD_PAT); cycle();
    check("ld", wb_wd_o, RD_PAT);
    set_mem(1'b1, 1'b1, 1'b1, 5'd15, 3'b111, 3'd0, 64'd0, RD_PAT); cycle();
    check("f3_111_we", {63'd0, wb_we_o}, 64'd0);

    // x0 write is suppressed and never bypassed.
    set_mem(1'b1, 1'b1, 1'b0, 5'd0, 3'd0, 3'd0, 64'h1111, 64'd0); cycle();
    check_bypass(5'd0, 5'd0, 64'h77, 64'h88);
    check("x0_byp_lit", id_rs1_data_o, 64'h77);

    // Flush of a valid write.
    set_mem(1'b1, 1'b1, 1'b0, 5'd6, 3'd0, 3'd0, 64'h66, 64'd0);
    flush_i = 1'b1; cycle(); flush_i = 1'b0;

    // Flush and stall together: bubble.
    cycle();
    flush_i = 1'b1; stall_i = 1'b1; cycle(); flush_i = 1'b0; stall_i = 1'b0;
    check("flush_stall_valid", {63'd0, wb_valid_o}, 64'd0);

    // Bypass of x7.
    set_mem(1'b1, 1'b1, 1'b0, 5'd7, 3'd0, 3'd0, 64'hDEAD, 64'd0); cycle();
    check_bypass(5'd7, 5'd8, 64'd0, 64'h55);
    check("byp_x7_lit", id_rs1_data_o, 64'hDEAD);
    check("byp_x8_lit", id_rs2_data_o, 64'h55);

    // Stall held three cycles while the MEM inputs change.
    set_mem(1'b1, 1'b1, 1'b0, 5'd9, 3'd0, 3'd0, 64'h99, 64'd0); cycle();
    stall_i = 1'b1;
    set_mem(1'b1, 1'b1, 1'b0, 5'd12, 3'd0, 3'd0, 64'h77, 64'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_hold_wd", wb_wd_o, 64'h99);
    end
    stall_i = 1'b0;
    cycle();

`ifdef WB_RETIRE_CNT_EN
    // Counter: reset, five valid instructions, then a two-cycle stall.
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_mem(1'b1, 1'b0, 1'b0, 5'(i + 1), 3'd0, 3'd0, 64'(i), 64'd0);
      cycle();
    end
    check("cnt_four", retire_cnt_o, 64'd4);
    stall_i = 1'b1; cycle(); cycle(); stall_i = 1'b0;
    check("cnt_stalled", retire_cnt_o, 64'd4);
`endif

    // Random traffic with occasional stalls and flushes.
    for (int i = 0; i < 60; i++) begin
      set_mem(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
              5'($urandom), 3'($urandom), 3'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom});
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      cycle();
      stall_i = 1'b0; flush_i = 1'b0;
      check_bypass(($urandom_range(0, 1) != 0) ? wb_rd_o : 5'($urandom), 5'($urandom),
                   {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
